des_decrypt_iter: RTL and testbench



---
 rtl/des_decrypt_iter_if.sv | 24 ++
 rtl/des_decrypt_iter.sv | 193 +++++++++++++++++++
 tb/tb_des_decrypt_iter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/des_decrypt_iter_if.sv
// Handshake bundle for the iterative DES decryption core.
//   s_valid/s_ready/s_data/s_key : ciphertext + key offer (source -> core)
//   m_valid/m_ready/m_data       : plaintext delivery (core -> sink)
// Bit 63 of every 64-bit field is FIPS bit 1.
// Modports: slave = the core, master = the block driving/consuming it.
interface des_decrypt_iter_if;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_data;
    logic [63:0] s_key;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;

    modport slave (
        input  s_valid, s_data, s_key, m_ready,
        output s_ready, m_valid, m_data
    );

    modport master (
        output s_valid, s_data, s_key, m_ready,
        input  s_ready, m_valid, m_data
    );
endinterface

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption: one Feistel round per clock, 16 rounds per block.
// Subkeys are produced on the fly in reverse order by right-rotating C/D.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : des_decrypt_iter_if.slave (input offer, output delivery)
//   busy       : high while a block is in ROUND or DONE
//   key_err    : key byte parity error (only with DES_DECR_KEY_PARITY_CHECK_EN)
// Optional feature macro: DES_DECR_KEY_PARITY_CHECK_EN
//
// state | meaning
// IDLE  | ready for a ciphertext/key offer
// ROUND | running rounds 1..16 (cnt = current round)
// DONE  | plaintext presented, waiting for m_ready
module des_decrypt_iter (
    input  logic              clk,
    input  logic              rst_n,
    des_decrypt_iter_if.slave bus,
    output logic              busy
`ifdef DES_DECR_KEY_PARITY_CHECK_EN
    ,
    output logic              key_err
`endif
);
    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                  10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                  63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                  14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                                  41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    // Each entry: rows 0..3 of one S-box, 16 nibbles per row, MSB first.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

    function automatic logic [63:0] ip(input logic [63:0] x);
        logic [63:0] y;
        for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - IP_T[6'(j)])];
        return y;
    endfunction

    function automatic logic [63:0] fp(input logic [63:0] x);
        logic [63:0] y;
        for (int j = 0; j < 64; j++) y[6'(63 - j)] = x[6'(64 - FP_T[6'(j)])];
        return y;
    endfunction

    function automatic logic [55:0] pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int j = 0; j < 56; j++) y[6'(55 - j)] = x[6'(64 - PC1_T[6'(j)])];
        return y;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int j = 0; j < 48; j++) y[6'(47 - j)] = x[6'(56 - PC2_T[6'(j)])];
        return y;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s;
        logic [31:0] y;
        logic [5:0]  b;
        logic [5:0]  idx;
        for (int j = 0; j < 48; j++) e[6'(47 - j)] = r[5'(32 - E_T[6'(j)])];
        e = e ^ k;
        for (int i = 0; i < 8; i++) begin
            b   = e[6'(47 - 6 * i) -: 6];
            // row = outer bits, column = inner four bits
            idx = {b[5], b[0], b[4:1]};
            s[5'(31 - 4 * i) -: 4] = SBOX[3'(i)][8'(255 - 4 * int'(idx)) -: 4];
        end
        for (int j = 0; j < 32; j++) y[5'(31 - j)] = s[5'(32 - P_T[5'(j)])];
        return y;
    endfunction

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] l_q, r_q;
    logic [27:0] c_q, d_q;
    logic [4:0]  cnt;
    logic [27:0] c_rot, d_rot;
    logic [47:0] subkey;
    logic [31:0] r_new;
    logic        last_round;

    // Decryption walks the encryption schedule backwards: round d undoes
    // encryption shift 18-d, so C/D start from PC1 (= C16/D16) unrotated.
    always_comb begin
        c_rot = c_q;
        d_rot = d_q;
        if (cnt == 5'd2 || cnt == 5'd9 || cnt == 5'd16) begin
            c_rot = {c_q[0], c_q[27:1]};
            d_rot = {d_q[0], d_q[27:1]};
        end else if (cnt != 5'd1) begin
            c_rot = {c_q[1:0], c_q[27:2]};
            d_rot = {d_q[1:0], d_q[27:2]};
        end
        subkey     = pc2({c_rot, d_rot});
        r_new      = l_q ^ feistel(r_q, subkey);
        last_round = (cnt == 5'd16);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        bus.s_ready = 1'b0;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                bus.s_ready = 1'b1;
                busy        = 1'b0;
                if (bus.s_valid) state_nxt = ROUND;
            end
            ROUND:   if (last_round) state_nxt = DONE;
            DONE:    if (bus.m_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            cnt         <= '0;
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.s_valid) begin
                    {l_q, r_q} <= ip(bus.s_data);
                    {c_q, d_q} <= pc1(bus.s_key);
                    cnt        <= 5'd1;
                end
                ROUND: begin
                    c_q <= c_rot;
                    d_q <= d_rot;
                    l_q <= r_q;
                    r_q <= r_new;
                    cnt <= last_round ? 5'd0 : cnt + 5'd1;
                    if (last_round) begin
                        // halves swapped ahead of FP: {R16, L16}
                        bus.m_data  <= fp({r_new, r_q});
                        bus.m_valid <= 1'b1;
                    end
                end
                DONE: if (bus.m_ready) bus.m_valid <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef DES_DECR_KEY_PARITY_CHECK_EN
    function automatic logic parity_bad(input logic [63:0] k);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) if (!(^k[6'(8 * i) +: 8])) bad = 1'b1;
        return bad;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 key_err <= 1'b0;
        else if (state == IDLE && bus.s_valid)      key_err <= parity_bad(bus.s_key);
    end
`else
    // Parity bits are simply dropped by PC1; no flag is produced.
`endif
endmodule

// File: tb/tb_des_decrypt_iter.sv
// Self-checking bench for des_decrypt_iter: fixed vectors, backpressure,
// mid-block reset, back-to-back blocks and random blocks checked against a
// textbook DES model (forward key schedule, subkeys applied K16..K1).
module tb_des_decrypt_iter;
    localparam int T_IP = 0, T_FP = 1, T_E = 2, T_P = 3, T_PC1 = 4, T_PC2 = 5;

    int ip_t[$]  = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                     57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    int fp_t[$]  = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                     36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    int e_t[$]   = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                     16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    int p_t[$]   = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    int pc1_t[$] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                     63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    int pc2_t[$] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                     41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    int shift_t[$] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    int sbox_q[$] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,     0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,     15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,     3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,     13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,     13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,     1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,     13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,     3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,     14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,     11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,     10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,     4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,     13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,     6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,     1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,     2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

    localparam logic [63:0] K1 = 64'h133457799BBCDFF1, C1 = 64'h85E813540F0AB405, P1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] K2 = 64'h0E329232EA6D0D73, C2 = 64'h0000000000000000, P2 = 64'h8787878787878787;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
`ifdef DES_DECR_KEY_PARITY_CHECK_EN
    logic key_err;
`endif
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    des_decrypt_iter_if bus();

    des_decrypt_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
`ifdef DES_DECR_KEY_PARITY_CHECK_EN
        ,
        .key_err (key_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Values are right-aligned; FIPS bit 1 of an n-bit value is bit n-1.
    function automatic logic [63:0] perm(input logic [63:0] x, input int n_in, input int sel);
        logic [63:0] y;
        int n_out;
        int src;
        y = '0;
        case (sel)
            T_IP, T_FP: n_out = 64;
            T_PC1:      n_out = 56;
            T_P:        n_out = 32;
            default:    n_out = 48;
        endcase
        for (int j = 1; j <= n_out; j++) begin
            case (sel)
                T_IP:    src = ip_t[j-1];
                T_FP:    src = fp_t[j-1];
                T_E:     src = e_t[j-1];
                T_P:     src = p_t[j-1];
                T_PC1:   src = pc1_t[j-1];
                default: src = pc2_t[j-1];
            endcase
            y[6'(n_out - j)] = x[6'(n_in - src)];
        end
        return y;
    endfunction

    function automatic logic [31:0] f_ref(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] e;
        logic [31:0] s;
        int six, row, col;
        e = 48'(perm(64'(r), 32, T_E)) ^ k;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            six = int'(e[6'(47 - 6 * i) -: 6]);
            row = ((six >> 4) & 2) | (six & 1);
            col = (six >> 1) & 15;
            s   = (s << 4) | 32'(sbox_q[i * 64 + row * 16 + col]);
        end
        return 32'(perm(64'(s), 32, T_P));
    endfunction

    function automatic logic [63:0] des_decrypt_ref(input logic [63:0] ct, input logic [63:0] key);
        logic [47:0] ks[$];
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [63:0] b;
        logic [31:0] l, r, t;
        cd = 56'(perm(key, 64, T_PC1));
        c  = cd[55:28];
        d  = cd[27:0];
        for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < shift_t[i]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            ks.push_back(48'(perm({8'h00, c, d}, 56, T_PC2)));
        end
        b = perm(ct, 64, T_IP);
        l = b[63:32];
        r = b[31:0];
        for (int i = 15; i >= 0; i--) begin
            t = r;
            r = l ^ f_ref(r, ks[i]);
            l = t;
        end
        return perm({r, l}, 64, T_FP);
    endfunction

    function automatic logic parity_err_ref(input logic [63:0] key);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) if ($countones(8'(key >> (8 * i))) % 2 == 0) bad = 1'b1;
        return bad;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Enter with the core idle; returns one cycle after the plaintext handshake.
    task automatic do_block(input string tag, input logic [63:0] ct, input logic [63:0] key,
                            input logic [63:0] exp);
        int n;
        check({tag, ".s_ready"}, 64'(bus.s_ready), 64'd1);
        bus.s_valid = 1'b1;
        bus.s_data  = ct;
        bus.s_key   = key;
        step();
        bus.s_valid = 1'b0;
        bus.s_data  = {$urandom, $urandom};
        bus.s_key   = {$urandom, $urandom};
`ifdef DES_DECR_KEY_PARITY_CHECK_EN
        check({tag, ".key_err"}, 64'(key_err), 64'(parity_err_ref(key)));
`endif
        n = 0;
        while (!bus.m_valid && n < 40) begin
            step();
            n++;
        end
        check({tag, ".latency"}, 64'(n), 64'd16);
        check({tag, ".m_data"}, bus.m_data, exp);
        check({tag, ".busy"}, 64'(busy), 64'd1);
        step();
        check({tag, ".m_valid_drop"}, 64'(bus.m_valid), 64'd0);
    endtask

    initial begin
        int n, t1, t2;
        logic [63:0] ct, key;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_key   = '0;
        bus.m_ready = 1'b1;

        #12;
        check("rst.s_ready", 64'(bus.s_ready), 64'd1);
        check("rst.m_valid", 64'(bus.m_valid), 64'd0);
        check("rst.m_data", bus.m_data, 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
`ifdef DES_DECR_KEY_PARITY_CHECK_EN
        check("rst.key_err", 64'(key_err), 64'd0);
`endif
        @(negedge clk) rst_n = 1'b1;
        step();

        do_block("vec1", C1, K1, P1);
        do_block("vec2", C2, K2, P2);

        // backpressure with spurious offers during ROUND and DONE
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = C1;
        bus.s_key   = K1;
        step();
        n = 0;
        while (!bus.m_valid && n < 40) begin
            bus.s_valid = 1'($urandom_range(0, 1));
            bus.s_data  = {$urandom, $urandom};
            bus.s_key   = {$urandom, $urandom};
            step();
            n++;
        end
        check("bp.latency", 64'(n), 64'd16);
        for (int i = 0; i < 10; i++) begin
            bus.s_valid = 1'($urandom_range(0, 1));
            bus.s_data  = {$urandom, $urandom};
            step();
            check("bp.m_data", bus.m_data, P1);
            check("bp.m_valid", 64'(bus.m_valid), 64'd1);
            check("bp.s_ready", 64'(bus.s_ready), 64'd0);
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        step();
        check("bp.release_m_valid", 64'(bus.m_valid), 64'd0);
        check("bp.release_s_ready", 64'(bus.s_ready), 64'd1);
        check("bp.hold_m_data", bus.m_data, P1);
        step();
        check("bp.no_accept", 64'(busy), 64'd0);

        // reset while round 7 is in flight
        bus.s_valid = 1'b1;
        bus.s_data  = C2;
        bus.s_key   = K2;
        step();
        bus.s_valid = 1'b0;
        repeat (6) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst.s_ready", 64'(bus.s_ready), 64'd1);
        check("mid_rst.m_valid", 64'(bus.m_valid), 64'd0);
        check("mid_rst.m_data", bus.m_data, 64'd0);
        check("mid_rst.busy", 64'(busy), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        step();
        do_block("post_rst", C1, K1, P1);

        // back-to-back with the offer held
        bus.s_valid = 1'b1;
        bus.s_data  = C1;
        bus.s_key   = K1;
        step();
        bus.s_data = C2;
        bus.s_key  = K2;
        n = 0;
        while (!bus.m_valid && n < 40) begin step(); n++; end
        t1 = cyc;
        check("b2b.first", bus.m_data, P1);
        n = 0;
        while (bus.m_valid && n < 40) begin step(); n++; end
        n = 0;
        while (!bus.m_valid && n < 40) begin step(); n++; end
        t2 = cyc;
        bus.s_valid = 1'b0;
        check("b2b.second", bus.m_data, P2);
        check("b2b.spacing", 64'(t2 - t1), 64'd18);
        step();
        step();
        check("b2b.idle_after", 64'(busy), 64'd0);

        for (int i = 0; i < 8; i++) begin
            ct  = {$urandom, $urandom};
            key = {$urandom, $urandom};
            do_block("rand", ct, key, des_decrypt_ref(ct, key));
        end

`ifdef DES_DECR_KEY_PARITY_CHECK_EN
        do_block("par_bad", C1, 64'h133457799BBCDFF0, P1);
        check("par_bad.key_err", 64'(key_err), 64'd1);
        do_block("par_ok", C1, K1, P1);
        check("par_ok.key_err", 64'(key_err), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
